tlb: RTL

Joint, fully associative MIPS32 TLB of `TLBNUM` entries, each mapping an even/odd page pair. It sits beside the CP0 register file. It has three jobs:
- answer the fetch-stage translation and the memory-stage translation / TLBP probe;
- accept TLBWI/TLBWR writes sourced from CP0 EntryHi/EntryLo0/EntryLo1/Index;
- return entry contents for TLBR, which CP0 latches into its TLB registers.

---
 rtl/tlb_pkg.sv | 32 +++
 rtl/tlb_search_port.sv | 40 ++++
 rtl/tlb.sv | 110 +++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB field widths, entry layout and the entry match rule.
// The optional random-replacement counter is enabled with the TLB_RANDOM_EN macro.
package tlb_pkg;

  localparam int VPN2_W  = 19;
  localparam int ASID_W  = 8;
  localparam int PFN_W   = 20;
  localparam int CATTR_W = 3;

  typedef struct packed {
    logic               e;
    logic [VPN2_W-1:0]  vpn2;
    logic [ASID_W-1:0]  asid;
    logic               g;
    logic [PFN_W-1:0]   pfn0;
    logic [CATTR_W-1:0] c0;
    logic               d0;
    logic               v0;
    logic [PFN_W-1:0]   pfn1;
    logic [CATTR_W-1:0] c1;
    logic               d1;
    logic               v1;
  } tlb_entry_t;

  // An entry hits when it exists, the VPN2 matches, and it is global or the ASID matches.
  function automatic logic entry_match(input tlb_entry_t ent,
                                       input logic [VPN2_W-1:0] vpn2,
                                       input logic [ASID_W-1:0] asid);
    return ent.e && (ent.vpn2 == vpn2) && (ent.g || (ent.asid == asid));
  endfunction

endpackage

// File: rtl/tlb_search_port.sv
// One combinational lookup port over all TLB entries; lowest matching index wins.
module tlb_search_port
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  tlb_entry_t [TLBNUM-1:0] entries,
  input  logic [VPN2_W-1:0]       vpn2,
  input  logic                    odd_page,
  input  logic [ASID_W-1:0]       asid,
  output logic                    found,
  output logic [IDXW-1:0]         index,
  output logic [PFN_W-1:0]        pfn,
  output logic [CATTR_W-1:0]      c,
  output logic                    d,
  output logic                    v
);

  // Scan from the top down so the lowest matching entry is the last one to overwrite the result.
  always_comb begin
    found = 1'b0;
    index = '0;
    pfn   = '0;
    c     = '0;
    d     = 1'b0;
    v     = 1'b0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (entry_match(entries[i], vpn2, asid)) begin
        found = 1'b1;
        index = i[IDXW-1:0];
        pfn   = odd_page ? entries[i].pfn1 : entries[i].pfn0;
        c     = odd_page ? entries[i].c1   : entries[i].c0;
        d     = odd_page ? entries[i].d1   : entries[i].d0;
        v     = odd_page ? entries[i].v1   : entries[i].v0;
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// Fully associative MIPS32 joint TLB: fetch port s0, data/TLBP port s1,
// TLBWI/TLBWR write port and combinational TLBR read port.
// Define TLB_RANDOM_EN to add the Random counter and the tlbwr write path.
module tlb
  import tlb_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [VPN2_W-1:0]  s0_vpn2,
  input  logic               s0_odd_page,
  input  logic [ASID_W-1:0]  s0_asid,
  output logic               s0_found,
  output logic [IDXW-1:0]    s0_index,
  output logic [PFN_W-1:0]   s0_pfn,
  output logic [CATTR_W-1:0] s0_c,
  output logic               s0_d,
  output logic               s0_v,
  input  logic [VPN2_W-1:0]  s1_vpn2,
  input  logic               s1_odd_page,
  input  logic [ASID_W-1:0]  s1_asid,
  output logic               s1_found,
  output logic [IDXW-1:0]    s1_index,
  output logic [PFN_W-1:0]   s1_pfn,
  output logic [CATTR_W-1:0] s1_c,
  output logic               s1_d,
  output logic               s1_v,
  input  logic               we,
  input  logic [IDXW-1:0]    w_index,
  input  logic [VPN2_W-1:0]  w_vpn2,
  input  logic [ASID_W-1:0]  w_asid,
  input  logic               w_g,
  input  logic [PFN_W-1:0]   w_pfn0,
  input  logic [CATTR_W-1:0] w_c0,
  input  logic               w_d0,
  input  logic               w_v0,
  input  logic [PFN_W-1:0]   w_pfn1,
  input  logic [CATTR_W-1:0] w_c1,
  input  logic               w_d1,
  input  logic               w_v1,
  input  logic [IDXW-1:0]    r_index,
  output logic [VPN2_W-1:0]  r_vpn2,
  output logic [ASID_W-1:0]  r_asid,
  output logic               r_g,
  output logic [PFN_W-1:0]   r_pfn0,
  output logic [CATTR_W-1:0] r_c0,
  output logic               r_d0,
  output logic               r_v0,
  output logic [PFN_W-1:0]   r_pfn1,
  output logic [CATTR_W-1:0] r_c1,
  output logic               r_d1,
  output logic               r_v1
`ifdef TLB_RANDOM_EN
  ,
  input  logic               tlbwr,
  output logic [IDXW-1:0]    rand_index
`endif
);

  tlb_entry_t [TLBNUM-1:0] entries;
  tlb_entry_t              w_entry;
  logic [IDXW-1:0]         w_target;

  assign w_entry = '{e: 1'b1, vpn2: w_vpn2, asid: w_asid, g: w_g,
                     pfn0: w_pfn0, c0: w_c0, d0: w_d0, v0: w_v0,
                     pfn1: w_pfn1, c1: w_c1, d1: w_d1, v1: w_v1};

`ifdef TLB_RANDOM_EN
  // Free-running Random counter; TLBNUM is a power of two so plain decrement wraps to TLBNUM-1.
  always_ff @(posedge clk) begin
    if (reset) rand_index <= IDXW'(TLBNUM - 1);
    else       rand_index <= rand_index - 1'b1;
  end

  assign w_target = (we && tlbwr) ? rand_index : w_index;
`else
  assign w_target = w_index;
`endif

  // Entry storage; reset clears everything and takes priority over a concurrent write.
  always_ff @(posedge clk) begin
    if (reset)   entries           <= '0;
    else if (we) entries[w_target] <= w_entry;
  end

  tlb_search_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s0 (
    .entries(entries), .vpn2(s0_vpn2), .odd_page(s0_odd_page), .asid(s0_asid),
    .found(s0_found), .index(s0_index), .pfn(s0_pfn), .c(s0_c), .d(s0_d), .v(s0_v)
  );

  tlb_search_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_s1 (
    .entries(entries), .vpn2(s1_vpn2), .odd_page(s1_odd_page), .asid(s1_asid),
    .found(s1_found), .index(s1_index), .pfn(s1_pfn), .c(s1_c), .d(s1_d), .v(s1_v)
  );

  assign r_vpn2 = entries[r_index].vpn2;
  assign r_asid = entries[r_index].asid;
  assign r_g    = entries[r_index].g;
  assign r_pfn0 = entries[r_index].pfn0;
  assign r_c0   = entries[r_index].c0;
  assign r_d0   = entries[r_index].d0;
  assign r_v0   = entries[r_index].v0;
  assign r_pfn1 = entries[r_index].pfn1;
  assign r_c1   = entries[r_index].c1;
  assign r_d1   = entries[r_index].d1;
  assign r_v1   = entries[r_index].v1;

endmodule
